alu_issue_ctrl: RTL and testbench

//   Single-issue sequencer in front of the SIMD ALU. Accepts one operation at a time over a valid/ready

---
 rtl/alu_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Single-issue sequencer in front of the SIMD ALU. One operation is accepted at a time over a
//   valid/ready request channel. Its opcode and operands are held on the ALU for the op's latency.
//   The result is then captured and returned, with per-word zero flags and the request tag, over a
//   valid/ready response channel.
//
//   Latency: ops 4, 6, 12, 28 and 30 take 1 cycle and op 20 takes 2 cycles. Every other opcode is
//   illegal. An illegal op skips the ALU and responds with out_err=1 and out_data=0.
//
// Ports
//   clk_fake, rst           clock; synchronous active-high reset
//   in_valid/in_ready       request handshake; in_op, in_a, in_b, in_tag carry the request
//   alu_op/alu_a/alu_b      drive to the ALU (alu_op=0 when idle); alu_result returns from it
//   out_valid/out_ready     response handshake; out_data, out_zero, out_tag, out_err carry it
//   busy                    high whenever the sequencer is not idle
//
// Configuration
//   ALU_ISSUE_PERF_EN       adds the saturating counters perf_ops and perf_stall
module alu_issue_ctrl #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk_fake,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [5:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_zero,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err,
  output logic              busy
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned WORD_W = DATA_W / 4;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e     state_q;
  logic [1:0] cnt_q;

  logic       op_legal;
  logic [1:0] op_lat_m1;
  logic [3:0] res_zero;

  // Opcode decode: legality and remaining EXEC cycles after the first.
  always_comb begin
    op_legal  = 1'b1;
    op_lat_m1 = 2'd0;
    case (in_op)
      6'd4, 6'd6, 6'd12, 6'd28, 6'd30: op_lat_m1 = 2'd0;
      6'd20:                           op_lat_m1 = 2'd1;
      default:                         op_legal  = 1'b0;
    endcase
  end

  always_comb begin
    res_zero = '0;
    for (int i = 0; i < 4; i++) begin
      res_zero[i] = (alu_result[i*WORD_W +: WORD_W] == '0);
    end
  end

  always_ff @(posedge clk_fake) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 2'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 4'hF;
      out_tag   <= '0;
      out_err   <= 1'b0;
      alu_op    <= 6'd0;
      alu_a     <= '0;
      alu_b     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // in_ready is always high here, so in_valid alone means accept.
          if (in_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            out_tag  <= in_tag;
            if (op_legal) begin
              alu_op  <= in_op;
              alu_a   <= in_a;
              alu_b   <= in_b;
              cnt_q   <= op_lat_m1;
              state_q <= StExec;
            end else begin
              // Illegal ops never reach the ALU; respond straight away.
              out_data  <= '0;
              out_zero  <= 4'hF;
              out_err   <= 1'b1;
              out_valid <= 1'b1;
              state_q   <= StResp;
            end
          end
        end
        StExec: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            out_data  <= alu_result;
            out_zero  <= res_zero;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            alu_op    <= 6'd0;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk_fake) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else if (state_q == StResp) begin
      if (out_ready && (perf_ops != 32'hFFFF_FFFF)) begin
        perf_ops <= perf_ops + 32'd1;
      end
      if (!out_ready && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl. A small behavioural ALU model answers alu_op/alu_a/alu_b;
// the expected results are hand-computed constants.
module tb_alu_issue_ctrl;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned TAG_W  = 4;

  logic              clk_fake = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [5:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_zero;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic              busy;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]       perf_ops;
  logic [31:0]       perf_stall;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_fake = ~clk_fake;

  alu_issue_ctrl #(
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk_fake  (clk_fake),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_result(alu_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .busy      (busy)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`endif
  );

  // ALU model: 4 halfword add, 20 per-word low-halfword multiply, 12 xor, 28 and, 30 or.
  always_comb begin
    alu_result = '0;
    for (int w = 0; w < 4; w++) begin
      case (alu_op)
        6'd4: begin
          alu_result[w*32 +: 16]      = alu_a[w*32 +: 16] + alu_b[w*32 +: 16];
          alu_result[w*32+16 +: 16]   = alu_a[w*32+16 +: 16] + alu_b[w*32+16 +: 16];
        end
        6'd20: alu_result[w*32 +: 32] = alu_a[w*32 +: 16] * alu_b[w*32 +: 16];
        6'd12: alu_result[w*32 +: 32] = alu_a[w*32 +: 32] ^ alu_b[w*32 +: 32];
        6'd28: alu_result[w*32 +: 32] = alu_a[w*32 +: 32] & alu_b[w*32 +: 32];
        6'd30: alu_result[w*32 +: 32] = alu_a[w*32 +: 32] | alu_b[w*32 +: 32];
        default: alu_result[w*32 +: 32] = 32'd0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_fake);
    #1;
  endtask

  // Present a request and hold it for the accepting edge, then withdraw it.
  task automatic issue(input logic [5:0] op, input logic [127:0] a, input logic [127:0] b,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    step();
    in_valid = 1'b0;
  endtask

  // Called in the cycle after accept; returns accept-to-out_valid cycles and ALU-busy cycles.
  task automatic wait_resp(output int lat, output int n_alu);
    lat   = 1;
    n_alu = 0;
    forever begin
      if (alu_op != 6'd0) n_alu++;
      if (out_valid || lat >= 20) break;
      step();
      lat++;
    end
  endtask

  localparam logic [127:0] HW1  = 128'h0001_0001_0001_0001_0001_0001_0001_0001;
  localparam logic [127:0] HW2  = 128'h0002_0002_0002_0002_0002_0002_0002_0002;
  localparam logic [127:0] HW3  = 128'h0003_0003_0003_0003_0003_0003_0003_0003;
  localparam logic [127:0] W9   = 128'h0000_0009_0000_0009_0000_0009_0000_0009;
  localparam logic [127:0] VA   = 128'h0000_0000_FFFF_0000_1234_5678_F0F0_F0F0;
  localparam logic [127:0] VB   = 128'h1111_1111_0F0F_0000_FFFF_0000_FFFF_FFFF;
  localparam logic [127:0] VAND = 128'h0000_0000_0F0F_0000_1234_0000_F0F0_F0F0;
  localparam logic [127:0] VOR  = 128'h1111_1111_FFFF_0000_FFFF_5678_FFFF_FFFF;

  initial begin
    int lat;
    int n_alu;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    step();
    step();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_zero", out_zero, 4'hF);
    check_eq("rst_out_tag", out_tag, 0);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_alu_op", alu_op, 0);
    check_eq("rst_alu_ab", {alu_a, alu_b} == '0, 1);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    step();

    // Reset in the middle of a 2-cycle op aborts it.
    issue(6'd20, HW3, HW3, 4'd1);
    check_eq("mid_exec_alu_op", alu_op, 20);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_alu_op", alu_op, 0);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    step();
    check_eq("abort_no_resp", out_valid, 0);

    // Backpressure: 5 stalled RESP cycles, with a request waiting that must not be taken.
    out_ready = 1'b0;
    issue(6'd28, VA, VB, 4'd9);
    wait_resp(lat, n_alu);
    check_eq("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_data", out_data, VAND);
      check_eq("bp_zero", out_zero, 4'b1000);
      check_eq("bp_tag", out_tag, 9);
      in_valid = 1'b1;
      in_op    = 6'd4;
      in_tag   = 4'd7;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef ALU_ISSUE_PERF_EN
    check_eq("perf_stall", perf_stall, 5);
`endif
    step();
    check_eq("bp_release_valid", out_valid, 0);
    check_eq("bp_release_in_ready", in_ready, 1);
`ifdef ALU_ISSUE_PERF_EN
    check_eq("perf_ops", perf_ops, 1);
`endif

    // Op 4: halfword add.
    issue(6'd4, HW1, HW1, 4'd3);
    check_eq("op4_busy", busy, 1);
    check_eq("op4_alu_op", alu_op, 4);
    check_eq("op4_alu_a", alu_a, HW1);
    wait_resp(lat, n_alu);
    check_eq("op4_lat", lat, 2);
    check_eq("op4_data", out_data, HW2);
    check_eq("op4_zero", out_zero, 0);
    check_eq("op4_tag", out_tag, 3);
    check_eq("op4_err", out_err, 0);
    step();
    check_eq("op4_idle", in_ready, 1);

    // Op 20: two-cycle multiply.
    issue(6'd20, HW3, HW3, 4'd2);
    wait_resp(lat, n_alu);
    check_eq("op20_lat", lat, 3);
    check_eq("op20_alu_cycles", n_alu, 2);
    check_eq("op20_data", out_data, W9);
    check_eq("op20_tag", out_tag, 2);
    step();

    // Illegal op: immediate error response, ALU untouched.
    issue(6'd63, HW3, HW1, 4'd4);
    wait_resp(lat, n_alu);
    check_eq("ill_lat", lat, 1);
    check_eq("ill_alu_cycles", n_alu, 0);
    check_eq("ill_err", out_err, 1);
    check_eq("ill_data", out_data, 0);
    check_eq("ill_zero", out_zero, 4'hF);
    check_eq("ill_tag", out_tag, 4);
    step();

    // Op 12 with a==b: all-zero result, error cleared.
    issue(6'd12, VA, VA, 4'd5);
    wait_resp(lat, n_alu);
    check_eq("op12_lat", lat, 2);
    check_eq("op12_data", out_data, 0);
    check_eq("op12_zero", out_zero, 4'hF);
    check_eq("op12_err", out_err, 0);
    step();

    // Back-to-back: op 28 then op 30 with in_valid held high.
    in_valid = 1'b1;
    in_op    = 6'd28;
    in_a     = VA;
    in_b     = VB;
    in_tag   = 4'd5;
    step();
    in_op  = 6'd30;
    in_tag = 4'd10;
    step();
    check_eq("b2b_first_valid", out_valid, 1);
    check_eq("b2b_first_tag", out_tag, 5);
    check_eq("b2b_first_data", out_data, VAND);
    check_eq("b2b_no_early_accept", in_ready, 0);
    step();
    check_eq("b2b_idle_ready", in_ready, 1);
    check_eq("b2b_idle_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    check_eq("b2b_second_alu_op", alu_op, 30);
    step();
    check_eq("b2b_second_valid", out_valid, 1);
    check_eq("b2b_second_tag", out_tag, 10);
    check_eq("b2b_second_data", out_data, VOR);
    check_eq("b2b_second_zero", out_zero, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
